// File: rtl/hazard_ctrl_pkg.sv
// +-------------------------------------------------------------------+
// | hazard_ctrl_pkg : shared state encodings, defaults and helpers     |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2
  } ctrl_state_t;

  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_MEM_TIMEOUT  = 255;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// +-------------------------------------------------------------------+
// | hazard_detect : combinational load-use hazard comparator           |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;
  logic ex_load;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign ex_load  = ex_valid & ex_mem_read & (ex_rd != 5'd0);
  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use = ex_load & id_valid & (rs1_hit | rs2_hit);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +-------------------------------------------------------------------+
// | hazard_ctrl : branch flush / dmem wait / load-use stall controller |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        combined_stall,
  output logic        pipe_freeze,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_count,
  output logic        mem_timeout
);

  localparam logic [1:0]  FLUSH_LOAD  = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
  localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

  ctrl_state_t state;
  ctrl_state_t next_state;
  logic [1:0]  flush_cnt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_next;
  logic        load_use;
  logic        mem_pend;
  logic        waiting;
  logic        load_flush;

  hazard_detect u_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign mem_pend   = dmem_req & ~dmem_ready;
  assign ctrl_state = state;

  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    combined_stall = 1'b0;
    pipe_freeze    = 1'b0;
    next_state     = state;
    waiting        = 1'b0;
    load_flush     = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (ex_branch_taken) begin
            if_id_flush    = 1'b1;
            combined_stall = 1'b1;
            load_flush     = 1'b1;
            next_state     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
          end else if (mem_pend) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            pipe_freeze = 1'b1;
            waiting     = 1'b1;
            next_state  = ST_MEMWAIT;
          end else if (load_use) begin
            pc_stall       = 1'b1;
            if_id_stall    = 1'b1;
            combined_stall = 1'b1;
          end
        end
        ST_FLUSH: begin
          // A data request arriving mid-flush stalls alongside the flush
          if_id_flush    = 1'b1;
          combined_stall = 1'b1;
          if (mem_pend) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            pipe_freeze = 1'b1;
            waiting     = 1'b1;
          end
          if (flush_cnt == 2'd0)
            next_state = mem_pend ? ST_MEMWAIT : ST_RUN;
        end
        ST_MEMWAIT: begin
          if (!dmem_ready) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            pipe_freeze = 1'b1;
            waiting     = 1'b1;
          end else begin
            next_state = ST_RUN;
          end
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  always_comb begin
    wait_next = 16'd0;
    if (waiting)
      wait_next = (state == ST_RUN) ? 16'd1 : sat_inc16(wait_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      flush_cnt   <= 2'd0;
      wait_cnt    <= 16'd0;
      stall_count <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_next;
      if (load_flush)
        flush_cnt <= FLUSH_LOAD;
      else if (state == ST_FLUSH && flush_cnt != 2'd0)
        flush_cnt <= flush_cnt - 2'd1;
      if (waiting && wait_next >= TIMEOUT_LIM)
        mem_timeout <= 1'b1;
      if (pc_stall)
        stall_count <= sat_inc16(stall_count);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// +-------------------------------------------------------------------+
// | tb_hazard_ctrl : directed self-checking bench for hazard_ctrl      |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        combined_stall;
  logic        pipe_freeze;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_count;
  logic        mem_timeout;
  logic [4:0]  outs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .combined_stall  (combined_stall),
    .pipe_freeze     (pipe_freeze),
    .ctrl_state      (ctrl_state),
    .stall_count     (stall_count),
    .mem_timeout     (mem_timeout)
  );

  // {pc_stall, if_id_stall, if_id_flush, combined_stall, pipe_freeze}
  assign outs = {pc_stall, if_id_stall, if_id_flush, combined_stall, pipe_freeze};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid        = 1'b0;
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    id_uses_rs1     = 1'b0;
    id_uses_rs2     = 1'b0;
    ex_valid        = 1'b0;
    ex_mem_read     = 1'b0;
    ex_rd           = 5'd0;
    ex_branch_taken = 1'b0;
    dmem_req        = 1'b0;
    dmem_ready      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    // reset with live hazards on the inputs
    ex_branch_taken = 1'b1;
    dmem_req        = 1'b1;
    tick();
    sample();
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_state", 32'(ctrl_state), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    tick();
    idle();
    reset = 1'b0;

    // load-use on rs2
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_valid = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    sample();
    check("lu_outs", 32'(outs), 32'(5'b11010));
    check("lu_state", 32'(ctrl_state), 32'd0);
    tick();
    ex_mem_read = 1'b0;
    sample();
    check("lu_release", 32'(outs), 32'd0);
    check("lu_count", 32'(stall_count), 32'd1);

    // non-hazard patterns
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
    sample();
    check("x0_nostall", 32'(outs), 32'd0);
    tick();
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd4; id_uses_rs2 = 1'b1;
    sample();
    check("nomatch", 32'(outs), 32'd0);
    tick();
    id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
    sample();
    check("unused_src", 32'(outs), 32'd0);
    tick();
    id_uses_rs1 = 1'b1; id_valid = 1'b0;
    sample();
    check("id_invalid", 32'(outs), 32'd0);
    tick();
    id_valid = 1'b1;
    sample();
    check("rs1_match", 32'(outs), 32'(5'b11010));
    tick();
    idle();
    sample();
    check("lu_count2", 32'(stall_count), 32'd2);

    // taken branch, two flush cycles
    tick();
    ex_branch_taken = 1'b1;
    sample();
    check("br_c1_outs", 32'(outs), 32'(5'b00110));
    check("br_c1_state", 32'(ctrl_state), 32'd0);
    tick();
    ex_branch_taken = 1'b0;
    sample();
    check("br_c2_outs", 32'(outs), 32'(5'b00110));
    check("br_c2_state", 32'(ctrl_state), 32'd1);
    tick();
    sample();
    check("br_done_outs", 32'(outs), 32'd0);
    check("br_done_state", 32'(ctrl_state), 32'd0);
    check("br_count", 32'(stall_count), 32'd2);

    // dmem wait of 4 cycles
    tick();
    do_reset();
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("mw_outs%0d", i), 32'(outs), 32'(5'b11001));
      check($sformatf("mw_state%0d", i), 32'(ctrl_state), (i == 0) ? 32'd0 : 32'd2);
      tick();
    end
    dmem_ready = 1'b1;
    sample();
    check("mw_ready_outs", 32'(outs), 32'd0);
    check("mw_ready_state", 32'(ctrl_state), 32'd2);
    tick();
    idle();
    sample();
    check("mw_done_state", 32'(ctrl_state), 32'd0);
    check("mw_count", 32'(stall_count), 32'd4);

    // timeout after 3 wait cycles, sticky until reset
    tick();
    do_reset();
    sample();
    check("to_clear", 32'(mem_timeout), 32'd0);
    tick();
    dmem_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sample();
      check($sformatf("to_wait%0d", i), 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    dmem_ready = 1'b1;
    tick();
    idle();
    tick();
    tick();
    sample();
    check("to_sticky", 32'(mem_timeout), 32'd1);
    tick();
    do_reset();
    sample();
    check("to_reset", 32'(mem_timeout), 32'd0);

    // branch + dmem wait together, then reset mid-MEMWAIT
    tick();
    ex_branch_taken = 1'b1; dmem_req = 1'b1;
    sample();
    check("mix_c1_outs", 32'(outs), 32'(5'b00110));
    tick();
    ex_branch_taken = 1'b0;
    sample();
    check("mix_c2_outs", 32'(outs), 32'(5'b11111));
    check("mix_c2_state", 32'(ctrl_state), 32'd1);
    tick();
    sample();
    check("mix_c3_outs", 32'(outs), 32'(5'b11001));
    check("mix_c3_state", 32'(ctrl_state), 32'd2);
    check("mix_c3_count", 32'(stall_count), 32'd1);
    tick();
    reset = 1'b1;
    sample();
    check("mix_rst_outs", 32'(outs), 32'd0);
    tick();
    sample();
    check("mix_rst_state", 32'(ctrl_state), 32'd0);
    check("mix_rst_count", 32'(stall_count), 32'd0);
    tick();
    idle();
    reset = 1'b0;
    sample();
    check("mix_after_outs", 32'(outs), 32'd0);
    check("mix_after_state", 32'(ctrl_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have a parameter FLUSH_CYCLES, default 2, giving the number of cycles IF/ID is flushed after a taken branch (legal 1..4).
REQ-002 The module SHALL have a parameter MEM_TIMEOUT, default 255, giving the number of dmem wait cycles before a timeout is flagged (legal 1..65535).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  ID holds a valid instruction.
REQ-006 id_rs1, id_rs2  in  5 each  ID source register indices.
REQ-007 id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads that source register.
REQ-008 ex_valid, ex_mem_read  in  1 each  EX holds a valid load.
REQ-009 ex_rd  in  5  EX destination register.
REQ-010 ex_branch_taken  in  1  EX resolved a taken branch this cycle.
REQ-011 dmem_req, dmem_ready  in  1 each  MEM-stage data request and its completion.
REQ-012 pc_stall, if_id_stall  out  1 each  hold PC / hold IF/ID.
REQ-013 if_id_flush  out  1  zero IF/ID.
REQ-014 combined_stall  out  1  insert a bubble into ID/EX.
REQ-015 pipe_freeze  out  1  freeze ID/EX, EX/MEM and MEM/WB.
REQ-016 ctrl_state  out  2  FSM state: RUN=0, FLUSH=1, MEMWAIT=2.
REQ-017 stall_count  out  16  saturating count of cycles with pc_stall=1.
REQ-018 mem_timeout  out  1  sticky dmem timeout flag.

Function
REQ-019 Load-use SHALL be detected combinationally as ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-020 Priority SHALL be taken branch > memory wait > load-use; only the winning event drives the outputs in a cycle.
REQ-021 RUN with ex_branch_taken:
- same cycle: if_id_flush=1 and combined_stall=1; pc_stall=0.
- next state: FLUSH if FLUSH_CYCLES>1, otherwise RUN.
- flush counter loaded with FLUSH_CYCLES-2.
REQ-022 FLUSH state:
- if_id_flush=1 and combined_stall=1 each cycle.
- counter decrements each cycle; return to RUN the cycle after it reads 0.
- total flush cycles = FLUSH_CYCLES.
REQ-023 RUN with dmem_req & !dmem_ready and no branch:
- pc_stall, if_id_stall and pipe_freeze = 1 same cycle.
- next state MEMWAIT; wait counter cleared to 1.
REQ-024 MEMWAIT state:
- pc_stall, if_id_stall and pipe_freeze = 1 while !dmem_ready.
- wait counter increments, saturating at 16 bits.
- on dmem_ready: all stall outputs 0 that cycle and next state is RUN.
- ex_branch_taken is ignored in MEMWAIT.
REQ-025 mem_timeout SHALL set when the wait counter reaches MEM_TIMEOUT while still waiting, and SHALL clear only on reset.
REQ-026 RUN with load-use only: pc_stall=if_id_stall=combined_stall=1 for exactly that cycle; state stays RUN.
REQ-027 A dmem_req arriving while in FLUSH SHALL be honoured:
- FLUSH outputs and MEMWAIT outputs are ORed.
- MEMWAIT is entered when the flush ends, if the request is still pending.
REQ-028 stall_count SHALL increment on every cycle with pc_stall=1 and saturate at 16'hFFFF.
REQ-029 No output SHALL depend combinationally on stall_count, the wait counter or mem_timeout.

Reset
REQ-030 While reset=1, every stall/flush/freeze output SHALL be driven 0, ctrl_state=RUN, all counters=0 and mem_timeout=0.
REQ-031 Reset asserted mid-FLUSH or mid-MEMWAIT SHALL abort the sequence; the first cycle after reset behaves as RUN.

Structure
REQ-032 The state encodings and the default values of FLUSH_CYCLES and MEM_TIMEOUT SHALL live in the shared core package.
REQ-033 Load-use comparison SHALL be a sub-module, hazard_detect (purely combinational); the FSM and counters stay in hazard_ctrl.

Verification
REQ-034 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_stall=if_id_stall=combined_stall=1 for 1 cycle, then 0; stall_count=1.
REQ-035 ex_rd=0 load with id_rs1=0 -> no stall.
REQ-036 Branch with FLUSH_CYCLES=2 -> if_id_flush=1 for exactly 2 cycles; ctrl_state goes 0,1,0.
REQ-037 dmem_ready low for 4 cycles -> pipe_freeze=1 for 4 cycles, released on the ready cycle; stall_count=4.
REQ-038 MEM_TIMEOUT=3 with a 5-cycle wait -> mem_timeout rises on the 3rd wait cycle and stays high until reset.
REQ-039 Simultaneous branch, dmem wait and reset pulse mid-MEMWAIT -> branch wins in the first cycle; after reset all outputs are 0 and ctrl_state=0.
